// File: rtl/ecpri_rx_ctrl.sv
// ecpri_rx_ctrl -- receive-side eCPRI Remote Memory Access engine.
//
// Purpose:
//   Reads a stored Ethernet frame byte by byte from the Ethernet receive RAM.
//   It copies the 14-byte Ethernet header into the header RAM and parses the
//   eCPRI common header and the RMA header. For a write request it copies the
//   data bytes into the CPRI payload RAM. For a read request it signals the
//   transmit side with the requested length.
//
// Ports:
//   clk, reset            single rising-edge clock; synchronous active-high reset
//   recv_pkt              new-frame indication (rising-edge detected)
//   inp_data_fifo         frame length in bytes, sampled on the recv_pkt rise
//   addr_1/data_1/we_1/oe_1  Ethernet RAM port (read only; data_1 never driven)
//   addr_0/data_0/we_0/oe_0  Ethernet-header RAM port (write only)
//   addr_2/data_2/we_2/oe_2  CPRI payload RAM port (write only)
//   send_write_resp       one-cycle pulse when a write request has completed
//   send_read_resp        one-cycle pulse when a read request was received
//   resp_payload_len      low byte of the RMA data length
//
// Build option:
//   ECPRI_RX_ETYPE_CHECK_EN  when defined, a frame whose EtherType is not
//                            0xAEFE is dropped once its header copy finishes.

module ecpri_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recv_pkt,
  input  logic [DATA_WIDTH-1:0] inp_data_fifo,
  output logic [ADDR_WIDTH-1:0] addr_1,
  inout  wire  [DATA_WIDTH-1:0] data_1,
  output logic                  we_1,
  output logic                  oe_1,
  output logic [ADDR_WIDTH-1:0] addr_0,
  inout  wire  [DATA_WIDTH-1:0] data_0,
  output logic                  we_0,
  output logic                  oe_0,
  output logic [ADDR_WIDTH-1:0] addr_2,
  inout  wire  [DATA_WIDTH-1:0] data_2,
  output logic                  we_2,
  output logic                  oe_2,
  output logic                  send_write_resp,
  output logic                  send_read_resp,
  output logic [DATA_WIDTH-1:0] resp_payload_len
);

  typedef enum logic [2:0] {
    IDLE, ETH_HDR, ECPRI_HDR, RMA_HDR, WR_DATA, WR_FIN, RESP, DROP
  } state_t;

  state_t                state_q, state_d;
  logic                  recv_prev_q;
  logic [DATA_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [15:0]           rd_off_q, rd_off_d;    // next Ethernet RAM offset to read
  logic [16:0]           lim_q, lim_d;          // read offsets must stay below this
  logic [15:0]           cap_cnt_q, cap_cnt_d;  // offset of the byte now in inp_d
  logic                  v2_q, v2_d;            // RAM output register holds a requested byte
  logic                  inp_v_q, inp_v_d;
  logic [DATA_WIDTH-1:0] inp_d_q, inp_d_d;
  logic [3:0]            rw_q, rw_d;
  logic [DATA_WIDTH-1:0] len_hi_q, len_hi_d;
  logic [DATA_WIDTH-1:0] len_lo_q, len_lo_d;
  logic [15:0]           wr_addr_q, wr_addr_d;  // RMA address, then running payload address
`ifdef ECPRI_RX_ETYPE_CHECK_EN
  logic [DATA_WIDTH-1:0] etype_hi_q, etype_hi_d;
`endif

  logic [ADDR_WIDTH-1:0] addr_0_q, addr_0_d, addr_1_q, addr_1_d, addr_2_q, addr_2_d;
  logic [DATA_WIDTH-1:0] wdata0_q, wdata0_d, wdata2_q, wdata2_d;
  logic                  we_0_q, we_0_d, we_2_q, we_2_d, oe_1_q, oe_1_d;
  logic                  wr_resp_q, wr_resp_d, rd_resp_q, rd_resp_d;
  logic [DATA_WIDTH-1:0] resp_len_q, resp_len_d;

  logic        rise;
  logic        reading_q, reading_d;
  logic        past_end;
  logic [15:0] len_full;
  logic [16:0] end_off;

  assign rise      = recv_pkt & ~recv_prev_q;
  assign reading_q = state_q inside {ETH_HDR, ECPRI_HDR, RMA_HDR, WR_DATA};
  assign reading_d = state_d inside {ETH_HDR, ECPRI_HDR, RMA_HDR, WR_DATA};
  // The byte the parser waits for lies beyond the frame: it will never arrive.
  assign past_end  = {1'b0, cap_cnt_q} >= 17'(frame_len_q);
  // Valid only while byte 29 (length low byte) sits in inp_d.
  assign len_full  = {len_hi_q, inp_d_q};
  assign end_off   = 17'd30 + {1'b0, len_full};

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    rd_off_d    = rd_off_q;
    lim_d       = lim_q;
    cap_cnt_d   = cap_cnt_q;
    rw_d        = rw_q;
    len_hi_d    = len_hi_q;
    len_lo_d    = len_lo_q;
    wr_addr_d   = wr_addr_q;
`ifdef ECPRI_RX_ETYPE_CHECK_EN
    etype_hi_d  = etype_hi_q;
`endif
    addr_0_d    = addr_0_q;
    addr_1_d    = addr_1_q;
    addr_2_d    = addr_2_q;
    wdata0_d    = wdata0_q;
    wdata2_d    = wdata2_q;
    we_0_d      = 1'b0;
    we_2_d      = 1'b0;
    oe_1_d      = 1'b0;
    wr_resp_d   = 1'b0;
    rd_resp_d   = 1'b0;
    resp_len_d  = resp_len_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d     = ETH_HDR;
          frame_len_d = inp_data_fifo;
          rd_off_d    = '0;
          cap_cnt_d   = '0;
          lim_d       = 17'd30;
        end
      end

      ETH_HDR: begin
        if (inp_v_q) begin
          we_0_d    = 1'b1;
          addr_0_d  = ADDR_WIDTH'(cap_cnt_q);
          wdata0_d  = inp_d_q;
          cap_cnt_d = cap_cnt_q + 16'd1;
`ifdef ECPRI_RX_ETYPE_CHECK_EN
          if (cap_cnt_q == 16'd12) etype_hi_d = inp_d_q;
          if (cap_cnt_q == 16'd13)
            state_d = ({etype_hi_q, inp_d_q} != 16'hAEFE) ? DROP : ECPRI_HDR;
`else
          if (cap_cnt_q == 16'd13) state_d = ECPRI_HDR;
`endif
        end
      end

      ECPRI_HDR: begin
        if (past_end) begin
          state_d = DROP;
        end else if (inp_v_q) begin
          cap_cnt_d = cap_cnt_q + 16'd1;
          if (cap_cnt_q == 16'd15 && inp_d_q != 8'h04) state_d = DROP;
          else if (cap_cnt_q == 16'd17)                state_d = RMA_HDR;
        end
      end

      RMA_HDR: begin
        if (past_end) begin
          state_d = DROP;
        end else if (inp_v_q) begin
          cap_cnt_d = cap_cnt_q + 16'd1;
          case (cap_cnt_q)
            16'd19: begin
              if (inp_d_q[3:0] != 4'd0 || inp_d_q[7:4] > 4'd2) state_d = DROP;
              rw_d = inp_d_q[7:4];
            end
            16'd26: wr_addr_d[15:8] = inp_d_q;
            16'd27: wr_addr_d[7:0]  = inp_d_q;
            16'd28: len_hi_d        = inp_d_q;
            16'd29: begin
              len_lo_d = inp_d_q;
              if (rw_q == 4'd0) begin
                rd_resp_d  = 1'b1;
                resp_len_d = inp_d_q;
                state_d    = RESP;
              end else if (end_off > 17'(frame_len_q)) begin
                state_d = DROP;
              end else if (len_full == 16'd0) begin
                state_d = WR_FIN;
              end else begin
                lim_d   = end_off;
                state_d = WR_DATA;
              end
            end
            default: ;
          endcase
        end
      end

      WR_DATA: begin
        if (inp_v_q) begin
          we_2_d    = 1'b1;
          addr_2_d  = ADDR_WIDTH'(wr_addr_q);
          wdata2_d  = inp_d_q;
          wr_addr_d = wr_addr_q + 16'd1;  // wraps modulo 2^16
          cap_cnt_d = cap_cnt_q + 16'd1;
          if ({1'b0, cap_cnt_q} + 17'd1 == lim_q) state_d = WR_FIN;
        end
      end

      WR_FIN: begin
        // Entered once the last payload write is on the port.
        wr_resp_d  = (rw_q == 4'd1);
        resp_len_d = len_lo_q;
        state_d    = RESP;
      end

      RESP:    state_d = IDLE;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read issue: only while staying in a reading state, so no access leaks
    // into DROP or the response. The Ethernet header is read unconditionally;
    // later offsets must lie inside the frame.
    if (reading_q && reading_d && ({1'b0, rd_off_q} < lim_q) &&
        (rd_off_q < 16'd14 || {1'b0, rd_off_q} < 17'(frame_len_q))) begin
      oe_1_d   = 1'b1;
      addr_1_d = ADDR_WIDTH'(rd_off_q);
      rd_off_d = rd_off_q + 16'd1;
    end

    // Two-stage read pipeline matching the registered RAM output; flushed
    // whenever the frame is left so stale bytes never reach the next frame.
    v2_d    = oe_1_q & reading_d;
    inp_v_d = v2_q & reading_d;
    inp_d_d = data_1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      recv_prev_q <= 1'b0;
      frame_len_q <= '0;
      rd_off_q    <= '0;
      lim_q       <= '0;
      cap_cnt_q   <= '0;
      v2_q        <= 1'b0;
      inp_v_q     <= 1'b0;
      inp_d_q     <= '0;
      rw_q        <= '0;
      len_hi_q    <= '0;
      len_lo_q    <= '0;
      wr_addr_q   <= '0;
`ifdef ECPRI_RX_ETYPE_CHECK_EN
      etype_hi_q  <= '0;
`endif
      addr_0_q    <= '0;
      addr_1_q    <= '0;
      addr_2_q    <= '0;
      wdata0_q    <= '0;
      wdata2_q    <= '0;
      we_0_q      <= 1'b0;
      we_2_q      <= 1'b0;
      oe_1_q      <= 1'b0;
      wr_resp_q   <= 1'b0;
      rd_resp_q   <= 1'b0;
      resp_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      recv_prev_q <= recv_pkt;
      frame_len_q <= frame_len_d;
      rd_off_q    <= rd_off_d;
      lim_q       <= lim_d;
      cap_cnt_q   <= cap_cnt_d;
      v2_q        <= v2_d;
      inp_v_q     <= inp_v_d;
      inp_d_q     <= inp_d_d;
      rw_q        <= rw_d;
      len_hi_q    <= len_hi_d;
      len_lo_q    <= len_lo_d;
      wr_addr_q   <= wr_addr_d;
`ifdef ECPRI_RX_ETYPE_CHECK_EN
      etype_hi_q  <= etype_hi_d;
`endif
      addr_0_q    <= addr_0_d;
      addr_1_q    <= addr_1_d;
      addr_2_q    <= addr_2_d;
      wdata0_q    <= wdata0_d;
      wdata2_q    <= wdata2_d;
      we_0_q      <= we_0_d;
      we_2_q      <= we_2_d;
      oe_1_q      <= oe_1_d;
      wr_resp_q   <= wr_resp_d;
      rd_resp_q   <= rd_resp_d;
      resp_len_q  <= resp_len_d;
    end
  end

  assign addr_0           = addr_0_q;
  assign addr_1           = addr_1_q;
  assign addr_2           = addr_2_q;
  assign we_0             = we_0_q;
  assign we_1             = 1'b0;
  assign we_2             = we_2_q;
  assign oe_0             = 1'b0;
  assign oe_1             = oe_1_q;
  assign oe_2             = 1'b0;
  assign data_0           = we_0_q ? wdata0_q : {DATA_WIDTH{1'bz}};
  assign data_2           = we_2_q ? wdata2_q : {DATA_WIDTH{1'bz}};
  assign send_write_resp  = wr_resp_q;
  assign send_read_resp   = rd_resp_q;
  assign resp_payload_len = resp_len_q;

endmodule

// File: tb/tb_ecpri_rx_ctrl.sv
module tb_ecpri_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recv_pkt = 1'b0;
  logic [7:0]  inp_data_fifo = 8'd0;
  logic [15:0] addr_0, addr_1, addr_2;
  wire  [7:0]  data_0, data_1, data_2;
  logic        we_0, we_1, we_2, oe_0, oe_1, oe_2;
  logic        send_write_resp, send_read_resp;
  logic [7:0]  resp_payload_len;

  ecpri_rx_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .recv_pkt(recv_pkt), .inp_data_fifo(inp_data_fifo),
    .addr_1(addr_1), .data_1(data_1), .we_1(we_1), .oe_1(oe_1),
    .addr_0(addr_0), .data_0(data_0), .we_0(we_0), .oe_0(oe_0),
    .addr_2(addr_2), .data_2(data_2), .we_2(we_2), .oe_2(oe_2),
    .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
    .resp_payload_len(resp_payload_len)
  );

  always #5 clk = ~clk;

  // RAM models: Ethernet RAM with registered read, header and payload RAMs.
  logic [7:0] eth_mem [0:65535];
  logic [7:0] hdr_mem [0:65535];
  logic [7:0] pay_mem [0:65535];
  logic [7:0] eth_rd_q;
  always @(posedge clk) if (oe_1) eth_rd_q <= eth_mem[addr_1];
  assign data_1 = eth_rd_q;
  always @(posedge clk) if (we_0) hdr_mem[addr_0] <= data_0;
  always @(posedge clk) if (we_2) pay_mem[addr_2] <= data_2;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Scoreboards: {addr, data} for payload writes, {wr, rd, len} for responses.
  logic [23:0] exp_wr[$];
  logic [9:0]  exp_resp[$];
  logic [7:0]  data_buf [0:63];

  always @(negedge clk) begin
    if (!reset) begin
      if (we_2) begin
        check_cnt++;
        if (exp_wr.size() == 0) begin
          $display("FAIL wr_scoreboard: unexpected write addr=%h data=%h, required none", addr_2, data_2);
        end else begin
          logic [23:0] e;
          e = exp_wr.pop_front();
          if ({addr_2, data_2} !== e)
            $display("FAIL wr_scoreboard: got addr=%h data=%h, required addr=%h data=%h",
                     addr_2, data_2, e[23:8], e[7:0]);
          else pass_cnt++;
        end
        $display("wr   addr=%h data=%h", addr_2, data_2);
      end
      if (send_write_resp || send_read_resp) begin
        check_cnt++;
        if (exp_resp.size() == 0) begin
          $display("FAIL resp_scoreboard: unexpected resp wr=%0b rd=%0b len=%h, required none",
                   send_write_resp, send_read_resp, resp_payload_len);
        end else begin
          logic [9:0] r;
          r = exp_resp.pop_front();
          if ({send_write_resp, send_read_resp, resp_payload_len} !== r)
            $display("FAIL resp_scoreboard: got wr=%0b rd=%0b len=%h, required wr=%0b rd=%0b len=%h",
                     send_write_resp, send_read_resp, resp_payload_len, r[9], r[8], r[7:0]);
          else pass_cnt++;
        end
        $display("resp wr=%0b rd=%0b len=%h", send_write_resp, send_read_resp, resp_payload_len);
      end
    end
  end

  task automatic build_frame(input logic [7:0] msg, input logic [3:0] rw, input logic [3:0] rr,
                             input logic [15:0] addr, input logic [15:0] len,
                             input logic [15:0] etype);
    for (int i = 0; i < 12; i++) eth_mem[i] = 8'($urandom);
    eth_mem[12] = etype[15:8];  eth_mem[13] = etype[7:0];
    eth_mem[14] = 8'h10;        eth_mem[15] = msg;
    eth_mem[16] = 8'h00;        eth_mem[17] = 8'(len + 16'd12);
    eth_mem[18] = 8'h01;        eth_mem[19] = {rw, rr};
    for (int i = 20; i < 26; i++) eth_mem[i] = 8'h00;
    eth_mem[26] = addr[15:8];   eth_mem[27] = addr[7:0];
    eth_mem[28] = len[15:8];    eth_mem[29] = len[7:0];
    for (int i = 0; i < 64; i++) eth_mem[30 + i] = data_buf[i];
  endtask

  task automatic push_writes(input logic [15:0] addr, input int len);
    for (int i = 0; i < len; i++) exp_wr.push_back({16'(addr + 16'(i)), data_buf[i]});
  endtask

  task automatic start_frame(input logic [7:0] flen);
    @(negedge clk);
    inp_data_fifo = flen;
    recv_pkt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    recv_pkt = 1'b0;
    inp_data_fifo = 8'd0;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 64; i++) data_buf[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({addr_0, addr_1, addr_2} !== 48'h0)
      $display("FAIL reset_addr: got %h %h %h, required 0 0 0", addr_0, addr_1, addr_2);
    else pass_cnt++;
    check_cnt++;
    if ({we_0, we_1, we_2, oe_0, oe_1, oe_2} !== 6'b0)
      $display("FAIL reset_we_oe: got %b, required 000000", {we_0, we_1, we_2, oe_0, oe_1, oe_2});
    else pass_cnt++;
    check_cnt++;
    if ({send_write_resp, send_read_resp, resp_payload_len} !== 10'h0)
      $display("FAIL reset_resp: got %b %b %h, required 0 0 00", send_write_resp, send_read_resp, resp_payload_len);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    $display("reset done");
  endtask

  task automatic test_write();
    data_buf[0] = 8'hDE; data_buf[1] = 8'hAD; data_buf[2] = 8'hBE; data_buf[3] = 8'hEF;
    build_frame(8'h04, 4'd1, 4'd0, 16'h0010, 16'd4, 16'hAEFE);
    push_writes(16'h0010, 4);
    exp_resp.push_back({2'b10, 8'd4});
    start_frame(8'd34);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_wr.size() != 0 || exp_resp.size() != 0)
      $display("FAIL write_pending: got %0d writes %0d resps outstanding, required 0", exp_wr.size(), exp_resp.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (pay_mem[16 + i] !== data_buf[i])
        $display("FAIL write_payload[%0d]: got %h, required %h", 16 + i, pay_mem[16 + i], data_buf[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 14; i++) begin
      check_cnt++;
      if (hdr_mem[i] !== eth_mem[i])
        $display("FAIL write_hdr[%0d]: got %h, required %h", i, hdr_mem[i], eth_mem[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (resp_payload_len !== 8'd4)
      $display("FAIL write_len: got %h, required 04", resp_payload_len);
    else pass_cnt++;
    check_cnt++;
    if ({we_1, oe_0, oe_2} !== 3'b0)
      $display("FAIL unused_strobes: got %b, required 000", {we_1, oe_0, oe_2});
    else pass_cnt++;
    $display("test_write done");
  endtask

  task automatic test_read();
    fill_data();
    build_frame(8'h04, 4'd0, 4'd0, 16'h0200, 16'h0020, 16'hAEFE);
    exp_resp.push_back({2'b01, 8'h20});
    start_frame(8'd30);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_resp.size() != 0)
      $display("FAIL read_pending: got %0d resps outstanding, required 0", exp_resp.size());
    else pass_cnt++;
    check_cnt++;
    if (resp_payload_len !== 8'h20)
      $display("FAIL read_len: got %h, required 20", resp_payload_len);
    else pass_cnt++;
    $display("test_read done");
  endtask

  // Frames that must be dropped: nothing is pushed, so any write or
  // response the DUT produces is flagged by the scoreboard.
  task automatic test_drops();
    logic [7:0]  flen [0:3];
    logic [7:0]  msg  [0:3];
    logic [3:0]  rr   [0:3];
    logic [15:0] len  [0:3];
    flen = '{8'd34, 8'd34, 8'd20, 8'd34};
    msg  = '{8'h00, 8'h04, 8'h04, 8'h04};
    rr   = '{4'd0,  4'd0,  4'd0,  4'd1};
    len  = '{16'd4, 16'd8, 16'd0, 16'd4};
    for (int t = 0; t < 4; t++) begin
      fill_data();
      build_frame(msg[t], 4'd1, rr[t], 16'h0300, len[t], 16'hAEFE);
      start_frame(flen[t]);
      repeat (60) @(negedge clk);
      check_cnt++;
      if (oe_1 !== 1'b0 || resp_payload_len !== 8'h20)
        $display("FAIL drop_%0d: got oe_1=%b len=%h, required oe_1=0 len=20", t, oe_1, resp_payload_len);
      else pass_cnt++;
      $display("test_drops case %0d done", t);
    end
  endtask

  task automatic test_addr_wrap();
    fill_data();
    build_frame(8'h04, 4'd1, 4'd0, 16'hFFFF, 16'd2, 16'hAEFE);
    push_writes(16'hFFFF, 2);
    exp_resp.push_back({2'b10, 8'd2});
    start_frame(8'd32);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_wr.size() != 0 || exp_resp.size() != 0)
      $display("FAIL wrap_pending: got %0d writes %0d resps outstanding, required 0", exp_wr.size(), exp_resp.size());
    else pass_cnt++;
    check_cnt++;
    if (pay_mem[16'h0000] !== data_buf[1] || pay_mem[16'hFFFF] !== data_buf[0])
      $display("FAIL wrap_payload: got %h %h, required %h %h", pay_mem[16'hFFFF], pay_mem[16'h0000], data_buf[0], data_buf[1]);
    else pass_cnt++;
    $display("test_addr_wrap done");
  endtask

  task automatic test_no_resp_and_zero_len();
    fill_data();
    build_frame(8'h04, 4'd2, 4'd0, 16'h0400, 16'd3, 16'hAEFE);
    push_writes(16'h0400, 3);
    start_frame(8'd40);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_wr.size() != 0)
      $display("FAIL wr_noresp_pending: got %0d writes outstanding, required 0", exp_wr.size());
    else pass_cnt++;
    build_frame(8'h04, 4'd1, 4'd0, 16'h0500, 16'd0, 16'hAEFE);
    exp_resp.push_back({2'b10, 8'd0});
    start_frame(8'd30);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_resp.size() != 0 || resp_payload_len !== 8'd0)
      $display("FAIL zero_len: got %0d resps outstanding len=%h, required 0 len=00", exp_resp.size(), resp_payload_len);
    else pass_cnt++;
    $display("test_no_resp_and_zero_len done");
  endtask

  task automatic test_reset_mid_write();
    int waited;
    fill_data();
    build_frame(8'h04, 4'd1, 4'd0, 16'h0040, 16'd16, 16'hAEFE);
    push_writes(16'h0040, 16);
    start_frame(8'd46);
    waited = 0;
    while (we_2 !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_cnt++;
    if (we_2 !== 1'b1) $display("FAIL midreset_wait: got no payload write, required one within 100 cycles");
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if ({addr_0, addr_1, addr_2, we_0, we_2, oe_1, send_write_resp, send_read_resp, resp_payload_len} !== 61'h0)
      $display("FAIL midreset_outputs: got addr %h %h %h we %b%b oe_1 %b resp %b%b len %h, required all 0",
               addr_0, addr_1, addr_2, we_0, we_2, oe_1, send_write_resp, send_read_resp, resp_payload_len);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    exp_wr.delete();
    repeat (5) @(negedge clk);
    $display("test_reset_mid_write done");
  endtask

  task automatic test_etype();
    fill_data();
    build_frame(8'h04, 4'd1, 4'd0, 16'h0100, 16'd4, 16'h0800);
`ifndef ECPRI_RX_ETYPE_CHECK_EN
    push_writes(16'h0100, 4);
    exp_resp.push_back({2'b10, 8'd4});
`endif
    start_frame(8'd34);
    repeat (60) @(negedge clk);
    check_cnt++;
    if (exp_wr.size() != 0 || exp_resp.size() != 0)
      $display("FAIL etype_pending: got %0d writes %0d resps outstanding, required 0", exp_wr.size(), exp_resp.size());
    else pass_cnt++;
    $display("test_etype done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drops();
    test_addr_wrap();
    test_no_resp_and_zero_len();
    test_reset_mid_write();
    test_etype();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
